// File: rtl/vga_sched_pkg.sv
// Shared VGA timing defaults and the vblank scheduler state encoding.
package vga_sched_pkg;

  localparam int unsigned VGA_H_TOTAL   = 800;
  localparam int unsigned VGA_V_TOTAL   = 525;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_CNT_W     = 10;
  localparam int unsigned FRAME_CNT_W   = 16;

  typedef enum logic [1:0] {
    CLOSED,
    IDLE,
    GRANTED
  } sched_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
// Purely combinational; the caller registers the result.
module rr_priority_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [$clog2(N)-1:0]  ptr,
  output logic [N-1:0]          win_c,
  output logic [$clog2(N)-1:0]  idx_c,
  output logic                  valid_c
);

  localparam int unsigned IW = $clog2(N);

  int unsigned cand;

  always_comb begin
    win_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = 0;
    // Offset 1..N from the pointer so the last winner is considered last.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!valid_c && req[IW'(cand)]) begin
        valid_c           = 1'b1;
        idx_c             = IW'(cand);
        win_c[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vblank_access_scheduler.sv
// Grants the shared sprite/framebuffer write port to one requester at a time,
// only inside the vertical-blanking window. Define FRAME_COUNTER_EN to add the
// 16-bit frame_count game-tick output.
module vblank_access_scheduler
  import vga_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_HOLD  = 800,
  parameter int unsigned GUARD     = 16,
  parameter int unsigned H_TOTAL   = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL   = VGA_V_TOTAL,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [VGA_CNT_W-1:0]        h_counter,
  input  logic [VGA_CNT_W-1:0]        v_counter,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic                        busy,
  output logic                        abort,
  output logic                        frame_start
`ifdef FRAME_COUNTER_EN
  ,
  output logic [FRAME_CNT_W-1:0]      frame_count
`endif
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [VGA_CNT_W-1:0] V_OPEN    = VGA_CNT_W'(V_VISIBLE);
  localparam logic [VGA_CNT_W-1:0] V_LAST    = VGA_CNT_W'(V_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] H_CLOSE   = VGA_CNT_W'(H_TOTAL - GUARD);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]      PTR_INIT  = ID_W'(NUM_REQ - 1);

  sched_state_t        state;
  logic                win_c;
  logic                win_q;
  logic [HOLD_W-1:0]   hold;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  pick_win_c;
  logic [ID_W-1:0]     pick_idx_c;
  logic                pick_valid_c;

  // Window closes GUARD pixels before the last line ends so writes settle.
  assign win_c = (v_counter >= V_OPEN) &&
                 !((v_counter == V_LAST) && (h_counter >= H_CLOSE));

  rr_priority_picker #(
    .N       (NUM_REQ)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .win_c   (pick_win_c),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CLOSED;
      win_q       <= 1'b0;
      gnt         <= '0;
      gnt_id      <= '0;
      busy        <= 1'b0;
      abort       <= 1'b0;
      frame_start <= 1'b0;
      hold        <= '0;
      ptr         <= PTR_INIT;
    end else begin
      win_q       <= win_c;
      frame_start <= win_c & ~win_q;
      abort       <= 1'b0;
      case (state)
        // CLOSED may grant directly once the window is seen open.
        CLOSED, IDLE: begin
          if (!win_q) begin
            state <= CLOSED;
          end else if (pick_valid_c) begin
            gnt    <= pick_win_c;
            gnt_id <= pick_idx_c;
            busy   <= 1'b1;
            ptr    <= pick_idx_c;
            hold   <= '0;
            state  <= GRANTED;
          end else begin
            state <= IDLE;
          end
        end
        GRANTED: begin
          if (!win_q) begin
            gnt   <= '0;
            busy  <= 1'b0;
            abort <= 1'b1;
            state <= CLOSED;
          end else if (hold == HOLD_LAST) begin
            gnt   <= '0;
            busy  <= 1'b0;
            abort <= 1'b1;
            state <= IDLE;
          end else if (!req[gnt_id]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= CLOSED;
        end
      endcase
    end
  end

`ifdef FRAME_COUNTER_EN
  // Game tick: advances on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (win_c && !win_q) begin
      frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vblank_access_scheduler.sv
// Self-checking bench for vblank_access_scheduler: directed scenarios plus
// randomized requests/counter jumps against a behavioural model.
module tb_vblank_access_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int MAX_HOLD  = 8;
  localparam int GUARD     = 16;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int V_VISIBLE = 480;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] h_counter = '0;
  logic [9:0] v_counter = '0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       abort;
  logic       frame_start;
`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int hc = 0;
  int vc = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  vblank_access_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .MAX_HOLD  (MAX_HOLD),
    .GUARD     (GUARD),
    .H_TOTAL   (H_TOTAL),
    .V_TOTAL   (V_TOTAL),
    .V_VISIBLE (V_VISIBLE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .req         (req),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .abort       (abort),
    .frame_start (frame_start)
`ifdef FRAME_COUNTER_EN
    ,
    .frame_count (frame_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner = -1;
  int          m_held  = 0;
  int          m_last  = NUM_REQ - 1;
  bit          m_open  = 1'b0;
  bit          e_abort = 1'b0;
  bit          e_fs    = 1'b0;
  logic [15:0] e_fc    = '0;

  function automatic bit in_window(int h, int v);
    return (v >= V_VISIBLE) && !(v == V_TOTAL - 1 && h >= H_TOTAL - GUARD);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit w;
    int c;
    if (!reset_n) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = NUM_REQ - 1;
      m_open  = 1'b0;
      e_abort = 1'b0;
      e_fs    = 1'b0;
      e_fc    = '0;
    end else begin
      w       = in_window(int'(h_counter), int'(v_counter));
      e_abort = 1'b0;
      if (m_owner >= 0) begin
        if (!m_open || m_held == MAX_HOLD - 1) begin
          m_owner = -1;
          e_abort = 1'b1;
        end else if (!req[m_owner]) begin
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else if (m_open && req != 4'b0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_last + k) % NUM_REQ;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_held = 0;
        m_last = m_owner;
      end
      e_fs = w && !m_open;
      if (e_fs) e_fc++;
      m_open = w;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic [3:0] eg;
    if (checking) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("abort", 32'(abort), 32'(e_abort));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
      else if (!reset_n) chk("gnt_id_rst", 32'(gnt_id), 32'd0);
`ifdef FRAME_COUNTER_EN
      chk("frame_count", 32'(frame_count), 32'(e_fc));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic adv();
    @(posedge clk);
    #1;
    hc++;
    if (hc == H_TOTAL) begin
      hc = 0;
      vc++;
      if (vc == V_TOTAL) vc = 0;
    end
    h_counter = 10'(hc);
    v_counter = 10'(vc);
  endtask

  task automatic jump(input int h, input int v);
    @(posedge clk);
    #1;
    hc = h;
    vc = v;
    h_counter = 10'(h);
    v_counter = 10'(v);
  endtask

  // Leaves the current cycle showing counters (0, V_VISIBLE).
  task automatic open_window();
    jump(H_TOTAL - 5, V_VISIBLE - 1);
    repeat (5) adv();
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 reset_n = 1'b0;
    jump(H_TOTAL - 10, V_VISIBLE - 1);
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Window open at t: frame_start at t+1, first grant at t+2.
  task automatic check_open(input string tag, input logic [3:0] exp_gnt);
    open_window();
    @(negedge clk);
    chk({tag, "_fs_t"}, 32'(frame_start), 32'd0);
    adv();
    @(negedge clk);
    chk({tag, "_fs_t1"}, 32'(frame_start), 32'd1);
    chk({tag, "_gnt_t1"}, 32'(gnt), 32'd0);
    adv();
    @(negedge clk);
    chk({tag, "_gnt_t2"}, 32'(gnt), 32'(exp_gnt));
  endtask

  initial begin
    int waited;
    int cnt;
    int r;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 checking = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Request pending outside the window, granted at window open.
    req = 4'b0001;
    jump(0, 100);
    repeat (20) begin
      adv();
      @(negedge clk);
      chk("t2_no_gnt_outside", 32'(gnt), 32'd0);
    end
    check_open("t2", 4'b0001);
    chk("t2_id", 32'(gnt_id), 32'd0);

    // Asynchronous reset mid-grant clears outputs without abort.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t1_gnt", 32'(gnt), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_id", 32'(gnt_id), 32'd0);
    chk("t1_abort", 32'(abort), 32'd0);
    chk("t1_fs", 32'(frame_start), 32'd0);
    jump(H_TOTAL - 10, V_VISIBLE - 1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    check_open("t1", 4'b0001);

    // Round-robin order 0,1,2,3 from a fresh pointer.
    req = 4'b1111;
    reset_pulse();
    open_window();
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        adv();
        @(negedge clk);
        waited++;
      end while (!busy && waited < 40);
      chk("t3_order", 32'(gnt_id), 32'(k));
      chk("t3_gnt", 32'(gnt), 32'(1 << k));
      repeat (5) adv();
      req[k] = 1'b0;
    end

    // Hold limit: eight cycles, abort, then the other requester.
    repeat (3) adv();
    req = 4'b0011;
    waited = 0;
    do begin
      adv();
      @(negedge clk);
      waited++;
    end while (!busy && waited < 40);
    chk("t5_first", 32'(gnt), 32'd1);
    cnt = 1;
    forever begin
      adv();
      @(negedge clk);
      if (gnt != 4'b0001 || cnt >= 20) break;
      cnt++;
    end
    chk("t5_hold_cycles", 32'(cnt), 32'd8);
    chk("t5_abort", 32'(abort), 32'd1);
    chk("t5_gnt_off", 32'(gnt), 32'd0);
    adv();
    @(negedge clk);
    chk("t5_next", 32'(gnt), 32'd2);
    chk("t5_abort_once", 32'(abort), 32'd0);

    // Forced revoke at window end, regrant next frame.
    req = 4'b0000;
    repeat (12) adv();
    jump(H_TOTAL - GUARD - 4, V_TOTAL - 1);
    req = 4'b0100;
    repeat (4) adv();
    adv();
    @(negedge clk);
    chk("t4_gnt_t1", 32'(gnt), 32'd4);
    adv();
    @(negedge clk);
    chk("t4_gnt_t2", 32'(gnt), 32'd0);
    chk("t4_abort_t2", 32'(abort), 32'd1);
    adv();
    @(negedge clk);
    chk("t4_abort_t3", 32'(abort), 32'd0);
    chk("t4_busy_t3", 32'(busy), 32'd0);
    check_open("t4", 4'b0100);

    // Three frames: frame_start (and frame_count) per frame.
    req = 4'b0000;
    reset_pulse();
    for (int f = 1; f <= 3; f++) begin
      open_window();
      adv();
      @(negedge clk);
      chk("t6_fs", 32'(frame_start), 32'd1);
`ifdef FRAME_COUNTER_EN
      chk("t6_frame_count", 32'(frame_count), 32'(f));
`endif
      jump(0, 100);
    end

    // Randomized phase.
    reset_pulse();
    for (int n = 0; n < 8000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        case ($urandom_range(0, 4))
          0, 1:    jump(H_TOTAL - 10, V_VISIBLE - 1);
          2, 3:    jump(H_TOTAL - GUARD - int'($urandom_range(1, 30)), V_TOTAL - 1);
          default: jump(int'($urandom_range(0, H_TOTAL - 1)), int'($urandom_range(0, V_TOTAL - 1)));
        endcase
      end else if (r == 3) begin
        reset_pulse();
      end else begin
        adv();
      end
      for (int b = 0; b < NUM_REQ; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 99) == 0) req = 4'b0000;
    end

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
